// File: rtl/io_out_port.sv
// io_out_port: captures IO store strobes from the CPU bus into a FIFO drained over valid/ready.
module io_out_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic [DATA_WIDTH-1:0]      bus_in,
    input  logic                       ovf_clr,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    assign count     = count_q;
    assign full      = count_q == CNT_FULL;
    assign empty     = count_q == '0;
    assign out_valid = ~empty;
    assign overflow  = overflow_q;
    // Gated so the port reads zero out of reset while storage is uninitialised.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        push       = go & ~full;
        pop        = out_valid & out_ready;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + CNT_ONE :
                     (pop && !push) ? count_q - CNT_ONE : count_q;
        overflow_d = (go & full) | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_in;
    end
endmodule

// File: tb/tb_io_out_port.sv
// tb_io_out_port: directed and scoreboarded checks of the IO output FIFO port.
module tb_io_out_port;
    logic       clk = 1'b0;
    logic       rst_n, go, ovf_clr, out_ready;
    logic [7:0] bus_in, out_data;
    logic       out_valid, full, empty, overflow;
    logic [2:0] count;
    int         n_cmp = 0;
    int         n_err = 0;

    io_out_port #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .bus_in(bus_in), .ovf_clr(ovf_clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seq [4];
    logic [7:0] words   [10];
    logic [7:0] q [$];
    logic       ovf_m, pv, mfull;
    logic [7:0] pd;
    int         burst;

    initial begin
        rst_n = 1'b0; go = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0; bus_in = 8'h00;
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        tick();
        rst_n = 1'b1;

        // single push, one-cycle latency
        go = 1'b1; bus_in = 8'h5A;
        tick();
        go = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data", 32'(out_data), 32'h5A);
        chk("t1_count", 32'(count), 32'h1);
        chk("t1_empty", 32'(empty), 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drain", 32'(empty), 32'h1);

        // fill, overflow, drain in order
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            go = 1'b1; bus_in = exp_seq[i];
            tick();
        end
        chk("t2_full", 32'(full), 32'h1);
        chk("t2_count", 32'(count), 32'h4);
        bus_in = 8'h55;
        tick();
        go = 1'b0;
        chk("t2_ovf", 32'(overflow), 32'h1);
        chk("t2_count5", 32'(count), 32'h4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_rd", 32'(out_data), 32'(exp_seq[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("t2_empty", 32'(empty), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t2_clr", 32'(overflow), 32'h0);

        // full with go and pop together; set beats clear
        exp_seq = '{8'h61, 8'h62, 8'h63, 8'h64};
        for (int i = 0; i < 4; i++) begin
            go = 1'b1; bus_in = exp_seq[i];
            tick();
        end
        bus_in = 8'h99; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_count", 32'(count), 32'h3);
        chk("t3_ovf", 32'(overflow), 32'h1);
        chk("t3_head", 32'(out_data), 32'h62);
        bus_in = 8'h77;
        tick();
        chk("t3_refill", 32'(count), 32'h4);
        ovf_clr = 1'b1; bus_in = 8'h88;
        tick();
        chk("t3_setwins", 32'(overflow), 32'h1);
        go = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("t3_clr", 32'(overflow), 32'h0);
        exp_seq = '{8'h62, 8'h63, 8'h64, 8'h77};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd", 32'(out_data), 32'(exp_seq[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", 32'(empty), 32'h1);

        // continuous streaming, pointers wrap
        for (int i = 0; i < 10; i++) words[i] = 8'(8'hA0 + i * 3);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            go = 1'b1; bus_in = words[i];
            tick();
            chk("t4_data", 32'(out_data), 32'(words[i]));
            chk("t4_count", 32'(count), 32'h1);
        end
        go = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("t4_empty", 32'(count), 32'h0);

        // clear without overflow event, then async reset mid-cycle
        go = 1'b1; bus_in = 8'hA1;
        tick();
        bus_in = 8'hA2;
        tick();
        chk("t5_count2", 32'(count), 32'h2);
        bus_in = 8'hA3; ovf_clr = 1'b1;
        tick();
        go = 1'b0; ovf_clr = 1'b0;
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_count3", 32'(count), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid", 32'(out_valid), 32'h0);
        chk("t5_rcount", 32'(count), 32'h0);
        chk("t5_rempty", 32'(empty), 32'h1);
        tick();
        rst_n = 1'b1;

        // random consumer, bursty producer, scoreboard
        ovf_m = 1'b0; pv = 1'b0; pd = 8'h00; burst = 0;
        for (int c = 0; c < 400; c++) begin
            chk("r_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("r_count", 32'(count), 32'(q.size()));
            chk("r_ovf", 32'(overflow), 32'(ovf_m));
            if (q.size() != 0) chk("r_data", 32'(out_data), 32'(q[0]));
            if (pv) chk("r_stable", 32'(out_data), 32'(pd));
            if (burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 6);
            go = burst > 0;
            if (burst > 0) burst--;
            bus_in = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            ovf_clr = $urandom_range(0, 15) == 0;
            pv = out_valid && !out_ready;
            pd = out_data;
            mfull = q.size() == 4;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (go && !mfull) q.push_back(bus_in);
            ovf_m = (go && mfull) || (ovf_m && !ovf_clr);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
